aes128_dec_ctrl: RTL
====================

# aes128_dec_ctrl

Iterative AES-128 decryption engine controller. It expands a loaded cipher key once into eleven stored round keys, then decrypts 128-bit blocks through a single shared inverse-round datapath, one round per clock. It sits between a ciphertext producer and a plaintext consumer, both using valid/ready handshakes. It replaces the fully unrolled 10-round decryptor where area matters more than throughput.

## Interface
- KEY_RETAIN, 1, 1: round keys persist across blocks until the next key load; 0: key_loaded clears after each output handshake, so every block needs a fresh key.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  cipher key offered
- key_ready  out  1  key load accepted this cycle if key_valid
- key  in  128  cipher key; bits [127:120] = first byte of FIPS-197 hex string
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted this cycle if in_valid
- in_data  in  128  ciphertext, same byte order as key
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same byte order
- busy  out  1  high in KEXP or DEC
- key_loaded  out  1  round keys valid

## Operation
- States: IDLE, KEXP, READY, DEC, DONE. Reset state is IDLE.
- IDLE: key_ready=1, in_ready=0. On key_valid: rk[0]<=key, rcon<=0x01, rcnt<=1, go to KEXP.
- KEXP: 10 cycles. Each cycle computes rk[rcnt] from rk[rcnt-1] (RotWord, SubWord, XOR rcon into byte 0, chained word XORs). rcon advances by xtime: 01,02,04,08,10,20,40,80,1b,36. After rk[10] is written: key_loaded<=1, go to READY.
- READY: key_ready=1; in_ready = !key_valid, so a key load beats a block in the same cycle. key_valid → KEXP (key_loaded<=0). in_valid&&in_ready → st<=in_data^rk[10], rcnt<=1, go to DEC.
- DEC: rcnt 1..9: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[10-rcnt]). rcnt=10: st <= InvSubBytes(InvShiftRows(st)) ^ rk[0], then go to DONE.
- DONE: out_valid=1, out_data=st, held stable until out_ready. On handshake:
  - KEY_RETAIN=1: go to READY. in_ready = out_ready && !key_valid in DONE, so a new block may be accepted in the same cycle and go directly to DEC (back-to-back).
  - KEY_RETAIN=0: key_loaded<=0, go to IDLE; in_ready=0 in DONE.
- key_ready=0 in KEXP, DEC and DONE. A key offered mid-block waits.
- All GF(2^8) arithmetic uses polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09.

## Timing
- Reset (async assert, clk-synchronous use after deassert): state=IDLE; out_valid, key_loaded, busy, in_ready = 0; key_ready=1; out_data=0; st, rk[], rcnt cleared.
- Key-load latency: key_loaded rises 10 cycles after the key handshake edge.
- Decrypt latency: out_valid rises 10 clock edges after the in handshake edge.
- Throughput: one block per 11 cycles when the consumer holds out_ready=1 and KEY_RETAIN=1.
- rst asserted mid-KEXP or mid-DEC: the operation is aborted, no out_valid pulse, key_loaded=0; a key reload is required.
- out_ready low in DONE stalls indefinitely with out_data unchanged; no input is accepted.
- busy is the registered state decode; no combinational path from inputs to busy.

## Structure
- Package aes_pkg:
  - sbox and inv_sbox functions
  - xtime and gf_mul functions
  - rcon step function
  - key-expansion step function (rk_next)
  - state enum
  - ROUNDS=10 constant
- Sub-module aes_inv_round: combinational, inputs st, rk and final flag (final skips InvMixColumns), output next st. Instantiated once.
- Round-key store: 11×128 register array in the controller.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f. Then check:
  - rk[10] = 13111d7fe3944a17f307a78b4d2b30c5
  - in 69c4e0d86a7b0430d8cdb78070b4c55a → out 00112233445566778899aabbccddeeff exactly 10 edges after accept
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 → out 3243f6a8885a308d313198a2e0370734.
- Back-to-back, KEY_RETAIN=1, out_ready=1: two C.1 blocks → outputs 11 cycles apart; second accepted in the first block's DONE cycle.
- Backpressure: out_ready low 5 cycles in DONE → out_data stable, in_ready=0, key_ready=0; released → single handshake.
- key_valid and in_valid both high in READY → key accepted, block not, KEXP entered, key_loaded low for 10 cycles.
- rst pulse at DEC rcnt=5 → all outputs at reset values, no out_valid, IDLE; a reload with C.1 key then decrypts correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative decryptor: controller states,
// GF(2^8) arithmetic, forward/inverse S-boxes and the key-schedule step.
package aes_pkg;

  localparam int unsigned ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_READY = 3'd2,
    ST_DEC   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-boxes are built from the field inverse plus the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon_next(input logic [7:0] rcon);
    return xtime(rcon);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-128 key-schedule step: four words of round key r from round key r-1.
  function automatic logic [127:0] rk_next(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] next_st
);

  logic [7:0] sr [16];
  logic [7:0] ak [16];
  logic [7:0] mc [16];

  // Byte i sits at st[127-8i], column c = i/4, row r = i%4.
  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[4*c + r] = st[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      ak[i] = inv_sbox(sr[i]) ^ rk[127 - 8*i -: 8];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c+0] = gf_mul(ak[4*c], 8'h0e) ^ gf_mul(ak[4*c+1], 8'h0b) ^
                  gf_mul(ak[4*c+2], 8'h0d) ^ gf_mul(ak[4*c+3], 8'h09);
      mc[4*c+1] = gf_mul(ak[4*c], 8'h09) ^ gf_mul(ak[4*c+1], 8'h0e) ^
                  gf_mul(ak[4*c+2], 8'h0b) ^ gf_mul(ak[4*c+3], 8'h0d);
      mc[4*c+2] = gf_mul(ak[4*c], 8'h0d) ^ gf_mul(ak[4*c+1], 8'h09) ^
                  gf_mul(ak[4*c+2], 8'h0e) ^ gf_mul(ak[4*c+3], 8'h0b);
      mc[4*c+3] = gf_mul(ak[4*c], 8'h0b) ^ gf_mul(ak[4*c+1], 8'h0d) ^
                  gf_mul(ak[4*c+2], 8'h09) ^ gf_mul(ak[4*c+3], 8'h0e);
    end
  end

  // Repack bytes, bypassing InvMixColumns on the last round.
  always_comb begin
    next_st = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      next_st[127 - 8*i -: 8] = last_round ? ak[i] : mc[i];
    end
  end

endmodule

// File: rtl/aes128_dec_ctrl.sv
// Iterative AES-128 decryptor: expands a loaded key once into eleven stored
// round keys, then runs one inverse round per clock on a shared datapath.
module aes128_dec_ctrl
  import aes_pkg::*;
#(
  parameter logic KEY_RETAIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         key_loaded
);

  state_t       state;
  logic [127:0] rk [0:ROUNDS];
  logic [127:0] st;
  logic [3:0]   rcnt;
  logic [7:0]   rcon;

  logic [127:0] rk_prev;
  logic [127:0] rk_cur;
  logic [127:0] rk_gen;
  logic [127:0] round_out;
  logic         last_step;

  assign last_step = (rcnt == 4'(ROUNDS));
  assign rk_gen    = rk_next(rk_prev, rcon);

  // Round-key selection: rk[rcnt-1] for expansion, rk[ROUNDS-rcnt] for decryption.
  always_comb begin
    rk_prev = '0;
    rk_cur  = '0;
    for (int unsigned i = 0; i < ROUNDS; i++) begin
      if (rcnt == 4'(i + 1)) rk_prev = rk[i];
    end
    for (int unsigned i = 0; i <= ROUNDS; i++) begin
      if (rcnt == 4'(ROUNDS - i)) rk_cur = rk[i];
    end
  end

  aes_inv_round u_round (
    .st         (st),
    .rk         (rk_cur),
    .last_round (last_step),
    .next_st    (round_out)
  );

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    key_ready = (state == ST_IDLE) || (state == ST_READY);
    in_ready  = 1'b0;
    if (state == ST_READY) in_ready = !key_valid;
    if (state == ST_DONE && KEY_RETAIN) in_ready = out_ready && !key_valid;
    out_valid = (state == ST_DONE);
    out_data  = (state == ST_DONE) ? st : '0;
    busy      = (state == ST_KEXP) || (state == ST_DEC);
  end

  // Controller FSM, key schedule and round-state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      st         <= '0;
      rcnt       <= '0;
      rcon       <= '0;
      key_loaded <= 1'b0;
      for (int unsigned i = 0; i <= ROUNDS; i++) rk[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            rk[0] <= key;
            rcon  <= 8'h01;
            rcnt  <= 4'd1;
            state <= ST_KEXP;
          end
        end
        ST_KEXP: begin
          for (int unsigned i = 1; i <= ROUNDS; i++) begin
            if (rcnt == 4'(i)) rk[i] <= rk_gen;
          end
          rcon <= rcon_next(rcon);
          if (last_step) begin
            rcnt       <= '0;
            key_loaded <= 1'b1;
            state      <= ST_READY;
          end else begin
            rcnt <= rcnt + 4'd1;
          end
        end
        ST_READY: begin
          if (key_valid) begin
            rk[0]      <= key;
            rcon       <= 8'h01;
            rcnt       <= 4'd1;
            key_loaded <= 1'b0;
            state      <= ST_KEXP;
          end else if (in_valid) begin
            st    <= in_data ^ rk[ROUNDS];
            rcnt  <= 4'd1;
            state <= ST_DEC;
          end
        end
        ST_DEC: begin
          st <= round_out;
          if (last_step) begin
            rcnt  <= '0;
            state <= ST_DONE;
          end else begin
            rcnt <= rcnt + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (KEY_RETAIN) begin
              // Back-to-back: a block offered during the output handshake skips READY.
              if (in_valid && !key_valid) begin
                st    <= in_data ^ rk[ROUNDS];
                rcnt  <= 4'd1;
                state <= ST_DEC;
              end else begin
                state <= ST_READY;
              end
            end else begin
              key_loaded <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
